// File: rtl/regfile_wb_arbiter_if.sv
// Bundles the pipeline writeback, late-requester and register-file write signals.
interface regfile_wb_arbiter_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DEPTH  = 2
);
    localparam int unsigned PendW = $clog2(DEPTH + 1);

    logic              p_valid;
    logic              p_ready;
    logic [1:0]        p_regdst;
    logic [ADDR_W-1:0] p_rt;
    logic [ADDR_W-1:0] p_rd;
    logic [DATA_W-1:0] p_data;
    logic              l_valid;
    logic              l_ready;
    logic [ADDR_W-1:0] l_dest;
    logic [DATA_W-1:0] l_data;
    logic [PendW-1:0]  l_pending;
    logic              l_killed;
    logic              rf_we;
    logic [ADDR_W-1:0] rf_waddr;
    logic [DATA_W-1:0] rf_wdata;

    // Requester side: pipeline, late units and the register file.
    modport master (
        output p_valid, p_regdst, p_rt, p_rd, p_data, l_valid, l_dest, l_data,
        input  p_ready, l_ready, l_pending, l_killed, rf_we, rf_waddr, rf_wdata
    );

    // Arbiter side.
    modport slave (
        input  p_valid, p_regdst, p_rt, p_rd, p_data, l_valid, l_dest, l_data,
        output p_ready, l_ready, l_pending, l_killed, rf_we, rf_waddr, rf_wdata
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter: in-order pipeline writeback vs. a small FIFO of
// late-completing results, with starvation forcing and write-after-write cancellation.
module regfile_wb_arbiter #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned DEPTH    = 2,
    parameter int unsigned MAX_WAIT = 4,
    parameter int unsigned RA_ADDR  = 31
) (
    input logic                 clk,
    input logic                 rst,
    regfile_wb_arbiter_if.slave bus
);
    localparam int unsigned PtrW  = $clog2(DEPTH);
    localparam int unsigned CntW  = $clog2(MAX_WAIT + 1);
    localparam int unsigned PendW = $clog2(DEPTH + 1);

    localparam logic [0:0] StNormal = 1'b0;
    localparam logic [0:0] StForce  = 1'b1;

    logic [0:0]        state_q, state_d;
    logic [CntW-1:0]   wait_q, wait_d;
    logic [PtrW:0]     wr_ptr_q, rd_ptr_q;
    logic [DEPTH-1:0]  vld_q, vld_d;
    logic [ADDR_W-1:0] dest_q [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic              killed_q, killed_d;
    logic              rf_we_q, rf_we_d;
    logic [ADDR_W-1:0] rf_waddr_q, rf_waddr_d;
    logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;

    logic [ADDR_W-1:0] pdest;
    logic [PtrW:0]     count;
    logic [PtrW-1:0]   rd_idx, wr_idx;
    logic              empty, full, push, pop, p_win, head_live;
    logic [DEPTH-1:0]  kill_vec;
    logic [PendW-1:0]  pend;

    assign count     = wr_ptr_q - rd_ptr_q;
    assign empty     = (count == '0);
    assign full      = (count == (PtrW + 1)'(DEPTH));
    assign rd_idx    = rd_ptr_q[PtrW-1:0];
    assign wr_idx    = wr_ptr_q[PtrW-1:0];
    assign push      = bus.l_valid && !full;
    assign head_live = !empty && vld_q[rd_idx];

    assign bus.p_ready   = (state_q == StNormal);
    assign bus.l_ready   = !full;
    assign bus.l_pending = pend;
    assign bus.l_killed  = killed_q;
    assign bus.rf_we     = rf_we_q;
    assign bus.rf_waddr  = rf_waddr_q;
    assign bus.rf_wdata  = rf_wdata_q;

    // Pipeline destination select; null requests (no write or $0) never claim the port.
    always_comb begin
        pdest = '0;
        unique case (bus.p_regdst)
            2'b00:   pdest = bus.p_rt;
            2'b01:   pdest = bus.p_rd;
            2'b10:   pdest = ADDR_W'(RA_ADDR);
            default: pdest = '0;
        endcase
        p_win = bus.p_valid && bus.p_ready && (bus.p_regdst != 2'b11) && (pdest != '0);
    end

    // Live-entry count for l_pending.
    always_comb begin
        pend = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            pend = pend + PendW'(vld_q[i]);
        end
    end

    // Arbitration, wait counting, kill detection and next write-port contents.
    always_comb begin
        state_d    = state_q;
        wait_d     = wait_q;
        pop        = 1'b0;
        kill_vec   = '0;
        rf_we_d    = 1'b0;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        if (state_q == StForce) begin
            // Forced slot lasts one cycle even if the head was cancelled meanwhile.
            pop     = !empty;
            wait_d  = '0;
            state_d = StNormal;
            if (head_live && dest_q[rd_idx] != '0) begin
                rf_we_d    = 1'b1;
                rf_waddr_d = dest_q[rd_idx];
                rf_wdata_d = data_q[rd_idx];
            end
        end else if (p_win) begin
            rf_we_d    = 1'b1;
            rf_waddr_d = pdest;
            rf_wdata_d = bus.p_data;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                kill_vec[i] = vld_q[i] && (dest_q[i] == pdest);
            end
            if (head_live) begin
                if (wait_q == CntW'(MAX_WAIT - 1)) begin
                    state_d = StForce;
                end
                wait_d = wait_q + CntW'(1);
            end else if (!empty) begin
                // Cancelled head drains for free alongside the pipeline write.
                pop    = 1'b1;
                wait_d = '0;
            end
        end else if (!empty) begin
            pop    = 1'b1;
            wait_d = '0;
            if (head_live && dest_q[rd_idx] != '0) begin
                rf_we_d    = 1'b1;
                rf_waddr_d = dest_q[rd_idx];
                rf_wdata_d = data_q[rd_idx];
            end
        end
        killed_d = |kill_vec;
        // Kill and pop act on existing slots first; a same-cycle push is younger and survives.
        vld_d = vld_q & ~kill_vec;
        if (pop) begin
            vld_d[rd_idx] = 1'b0;
        end
        if (push) begin
            vld_d[wr_idx] = 1'b1;
        end
    end

    // Control state, pointers and registered write port.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StNormal;
            wait_q     <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            vld_q      <= '0;
            killed_q   <= 1'b0;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_q     <= wait_d;
            wr_ptr_q   <= push ? wr_ptr_q + 1'b1 : wr_ptr_q;
            rd_ptr_q   <= pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
            vld_q      <= vld_d;
            killed_q   <= killed_d;
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
        end
    end

    // FIFO payload storage; validity is tracked separately so no reset is needed here.
    always_ff @(posedge clk) begin
        if (push) begin
            dest_q[wr_idx] <= bus.l_dest;
            data_q[wr_idx] <= bus.l_data;
        end
    end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter; expected register-file writes go through a scoreboard.
module tb_regfile_wb_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;
    logic [36:0] sb [$];

    regfile_wb_arbiter_if #(.DATA_W(32), .ADDR_W(5), .DEPTH(2)) bus ();

    regfile_wb_arbiter #(
        .DATA_W  (32),
        .ADDR_W  (5),
        .DEPTH   (2),
        .MAX_WAIT(4),
        .RA_ADDR (31)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic expect_wr(input logic [4:0] addr, input logic [31:0] data);
        sb.push_back({addr, data});
    endtask

    // Advance one cycle and compare any register-file write against the scoreboard head.
    task automatic tick();
        logic [36:0] e;
        @(posedge clk);
        #1;
        if (bus.rf_we === 1'b1) begin
            n_checks++;
            assert (sb.size() > 0) else begin
                n_fail++;
                $error("FAIL unexpected_wr: observed addr %0h data %0h expected no write",
                       bus.rf_waddr, bus.rf_wdata);
            end
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("wr_addr", 32'(bus.rf_waddr), 32'(e[36:32]));
                chk("wr_data", bus.rf_wdata, e[31:0]);
            end
        end
    endtask

    task automatic p_drive(input logic v, input logic [1:0] rd_sel, input logic [4:0] rd,
                           input logic [31:0] d);
        bus.p_valid  = v;
        bus.p_regdst = rd_sel;
        bus.p_rd     = rd;
        bus.p_data   = d;
    endtask

    task automatic l_drive(input logic v, input logic [4:0] dest, input logic [31:0] d);
        bus.l_valid = v;
        bus.l_dest  = dest;
        bus.l_data  = d;
    endtask

    initial begin
        p_drive(1'b0, 2'b01, 5'd0, 32'h0);
        bus.p_rt = 5'd3;
        l_drive(1'b0, 5'd0, 32'h0);

        // Reset state
        tick();
        tick();
        chk("rst_we", 32'(bus.rf_we), 32'd0);
        chk("rst_waddr", 32'(bus.rf_waddr), 32'd0);
        chk("rst_wdata", bus.rf_wdata, 32'd0);
        chk("rst_pending", 32'(bus.l_pending), 32'd0);
        chk("rst_killed", 32'(bus.l_killed), 32'd0);
        chk("rst_p_ready", 32'(bus.p_ready), 32'd1);
        chk("rst_l_ready", 32'(bus.l_ready), 32'd1);
        rst = 1'b0;
        tick();

        // P only: rd, $ra and rt destinations
        p_drive(1'b1, 2'b01, 5'd9, 32'hA5);
        chk("p_ready_idle", 32'(bus.p_ready), 32'd1);
        expect_wr(5'd9, 32'hA5);
        tick();
        chk("p_we", 32'(bus.rf_we), 32'd1);
        p_drive(1'b1, 2'b10, 5'd9, 32'h1234);
        expect_wr(5'd31, 32'h1234);
        tick();
        p_drive(1'b1, 2'b00, 5'd9, 32'h33);
        expect_wr(5'd3, 32'h33);
        tick();
        p_drive(1'b0, 2'b01, 5'd0, 32'h0);
        tick();
        chk("p_we_drop", 32'(bus.rf_we), 32'd0);

        // L only; a regdst=11 P request does not block it
        l_drive(1'b1, 5'd4, 32'h7);
        tick();
        l_drive(1'b0, 5'd0, 32'h0);
        chk("l_pend_1", 32'(bus.l_pending), 32'd1);
        chk("l_not_yet", 32'(bus.rf_we), 32'd0);
        p_drive(1'b1, 2'b11, 5'd9, 32'hDEAD);
        expect_wr(5'd4, 32'h7);
        tick();
        chk("l_we", 32'(bus.rf_we), 32'd1);
        chk("l_pend_0", 32'(bus.l_pending), 32'd0);
        p_drive(1'b0, 2'b01, 5'd0, 32'h0);

        // Starvation: four P wins, then one forced L slot, then the held P request
        l_drive(1'b1, 5'd5, 32'h55);
        tick();
        l_drive(1'b0, 5'd0, 32'h0);
        for (int i = 0; i < 4; i++) begin
            p_drive(1'b1, 2'b01, 5'(10 + i), 32'(32'h100 + i));
            chk("starve_p_ready", 32'(bus.p_ready), 32'd1);
            expect_wr(5'(10 + i), 32'(32'h100 + i));
            tick();
        end
        p_drive(1'b1, 2'b01, 5'd20, 32'hCC);
        chk("force_p_ready", 32'(bus.p_ready), 32'd0);
        expect_wr(5'd5, 32'h55);
        tick();
        chk("force_waddr", 32'(bus.rf_waddr), 32'd5);
        chk("resume_p_ready", 32'(bus.p_ready), 32'd1);
        expect_wr(5'd20, 32'hCC);
        tick();
        p_drive(1'b0, 2'b01, 5'd0, 32'h0);
        chk("starve_pend", 32'(bus.l_pending), 32'd0);

        // Full FIFO: third push held until a pop, order preserved
        p_drive(1'b1, 2'b01, 5'd1, 32'h11);
        l_drive(1'b1, 5'd6, 32'h61);
        expect_wr(5'd1, 32'h11);
        tick();
        p_drive(1'b1, 2'b01, 5'd2, 32'h22);
        l_drive(1'b1, 5'd7, 32'h71);
        expect_wr(5'd2, 32'h22);
        tick();
        chk("full_pend", 32'(bus.l_pending), 32'd2);
        chk("full_l_ready", 32'(bus.l_ready), 32'd0);
        p_drive(1'b1, 2'b01, 5'd3, 32'h3A);
        l_drive(1'b1, 5'd12, 32'hC1);
        expect_wr(5'd3, 32'h3A);
        tick();
        p_drive(1'b0, 2'b01, 5'd0, 32'h0);
        chk("full_held", 32'(bus.l_ready), 32'd0);
        expect_wr(5'd6, 32'h61);
        tick();
        chk("full_popped", 32'(bus.l_ready), 32'd1);
        expect_wr(5'd7, 32'h71);
        tick();
        l_drive(1'b0, 5'd0, 32'h0);
        expect_wr(5'd12, 32'hC1);
        tick();
        chk("full_drained", 32'(bus.l_pending), 32'd0);

        // WAW kill: older dest=8 cancelled, same-cycle push dest=8 survives
        l_drive(1'b1, 5'd8, 32'h81);
        tick();
        p_drive(1'b1, 2'b01, 5'd8, 32'h88);
        l_drive(1'b1, 5'd8, 32'h82);
        expect_wr(5'd8, 32'h88);
        tick();
        p_drive(1'b0, 2'b01, 5'd0, 32'h0);
        l_drive(1'b0, 5'd0, 32'h0);
        chk("kill_pulse", 32'(bus.l_killed), 32'd1);
        chk("kill_pend", 32'(bus.l_pending), 32'd1);
        tick();
        chk("kill_drain_we", 32'(bus.rf_we), 32'd0);
        chk("kill_pulse_end", 32'(bus.l_killed), 32'd0);
        expect_wr(5'd8, 32'h82);
        tick();
        chk("kill_survivor_data", bus.rf_wdata, 32'h82);
        chk("kill_done_pend", 32'(bus.l_pending), 32'd0);

        // $0 destinations never write
        l_drive(1'b1, 5'd0, 32'h99);
        tick();
        l_drive(1'b0, 5'd0, 32'h0);
        chk("zero_pend", 32'(bus.l_pending), 32'd1);
        tick();
        chk("zero_l_we", 32'(bus.rf_we), 32'd0);
        chk("zero_popped", 32'(bus.l_pending), 32'd0);
        p_drive(1'b1, 2'b01, 5'd0, 32'h77);
        tick();
        chk("zero_p_we", 32'(bus.rf_we), 32'd0);
        p_drive(1'b0, 2'b01, 5'd0, 32'h0);

        // Reset with two entries queued and FORCE pending
        l_drive(1'b1, 5'd14, 32'hE1);
        tick();
        for (int i = 0; i < 4; i++) begin
            p_drive(1'b1, 2'b01, 5'(16 + i), 32'(32'h200 + i));
            if (i == 0) l_drive(1'b1, 5'd15, 32'hF1);
            else l_drive(1'b0, 5'd0, 32'h0);
            expect_wr(5'(16 + i), 32'(32'h200 + i));
            tick();
        end
        p_drive(1'b0, 2'b01, 5'd0, 32'h0);
        chk("pre_rst_pend", 32'(bus.l_pending), 32'd2);
        chk("pre_rst_force", 32'(bus.p_ready), 32'd0);
        rst = 1'b1;
        tick();
        chk("mid_rst_we", 32'(bus.rf_we), 32'd0);
        chk("mid_rst_pend", 32'(bus.l_pending), 32'd0);
        chk("mid_rst_l_ready", 32'(bus.l_ready), 32'd1);
        chk("mid_rst_p_ready", 32'(bus.p_ready), 32'd1);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
        end
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
